bus_arb_nm: RTL and testbench

- Parametrised successor to the two-master/four-slave system bus.
- Connects NUM_M masters to NUM_S slaves over one shared address/data path.
- Arbitration is selectable between fixed-priority and round-robin. Grant is sticky, with an optional anti-starvation hold limit.
- Slave decode uses per-slave base/mask windows with a decode-error flag. The read-data return path has a registered select.
- Sits between master cores (CPU, DMA) and memory/peripheral slaves.

---
 rtl/bus_pkg.sv | 42 ++++
 rtl/bus_arbiter_rr.sv | 57 +++++
 rtl/bus_arb_nm.sv | 82 ++++++++
 tb/tb_bus_arb_nm.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants and arbitration helpers for the parametrised system bus.
// Helpers are sized for the largest supported master count (8).
package bus_pkg;

    localparam int MAX_M     = 8;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [31:0] DEF_S_BASE = {8'h40, 8'h20, 8'h10, 8'h00};
    localparam logic [31:0] DEF_S_MASK = {8'hC0, 8'hE0, 8'hF0, 8'hF0};

    function automatic logic [MAX_M-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic [2:0] fixed_pick(input logic [MAX_M-1:0] req);
        fixed_pick = '0;
        for (int i = MAX_M - 1; i >= 0; i--) begin
            if (req[i]) fixed_pick = 3'(i);
        end
    endfunction

    // First requester after owner, wrapping at num_m; owner itself is never scanned.
    function automatic logic [2:0] rr_pick(input logic [MAX_M-1:0] req,
                                           input logic [2:0]       owner,
                                           input int               num_m);
        logic found;
        int   idx;
        rr_pick = owner;
        found   = 1'b0;
        for (int k = 1; k < MAX_M; k++) begin
            idx = int'(owner) + k;
            if (idx >= num_m) idx = idx - num_m;
            if (k < num_m && !found && req[idx]) begin
                rr_pick = 3'(idx);
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// Sticky bus arbiter: fixed-priority or round-robin hand-over, with an optional
// limit on how long the owner may keep the bus while another master waits.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int NUM_M    = 2,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int MAX_HOLD = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] m_req,
    output logic [NUM_M-1:0] m_grant,
    output logic [2:0]       owner
);

    localparam logic [7:0] HOLD_LAST = (MAX_HOLD > 0) ? 8'(MAX_HOLD - 1) : 8'd0;

    logic [7:0]       hold_cnt;
    logic [MAX_M-1:0] req_x;
    logic [MAX_M-1:0] others;
    logic [MAX_M-1:0] grant_x;
    logic             own_req;
    logic             any_other;
    logic             force_sw;
    logic             do_switch;
    logic [2:0]       next_owner;

    always_comb begin
        req_x      = MAX_M'(m_req);
        own_req    = req_x[owner];
        others     = req_x & ~onehot(owner);
        any_other  = |others;
        force_sw   = (MAX_HOLD != 0) && own_req && any_other && (hold_cnt == HOLD_LAST);
        // A dropped request and a due forced switch collapse into one hand-over.
        do_switch  = (!own_req && any_other) || force_sw;
        next_owner = (ARB_MODE == ARB_RR) ? rr_pick(others, owner, NUM_M) : fixed_pick(others);
        grant_x    = onehot(next_owner);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner    <= 3'd0;
            hold_cnt <= 8'd0;
            m_grant  <= NUM_M'(1);
        end else if (do_switch) begin
            owner    <= next_owner;
            hold_cnt <= 8'd0;
            m_grant  <= NUM_M'(grant_x);
        end else if (!any_other) begin
            hold_cnt <= 8'd0;
        end else if (own_req && (MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/bus_arb_nm.sv
// NUM_M-master / NUM_S-slave shared bus: arbiter, owner datapath mux, window
// decode and a registered read-return select.
module bus_arb_nm
    import bus_pkg::*;
#(
    parameter int                  NUM_M    = 2,
    parameter int                  NUM_S    = 4,
    parameter int                  AW       = 8,
    parameter int                  DW       = 32,
    parameter int                  ARB_MODE = ARB_FIXED,
    parameter int                  MAX_HOLD = 0,
    parameter logic [NUM_S*AW-1:0] S_BASE   = (NUM_S*AW)'(DEF_S_BASE),
    parameter logic [NUM_S*AW-1:0] S_MASK   = (NUM_S*AW)'(DEF_S_MASK)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_M-1:0]    m_req,
    input  logic [NUM_M-1:0]    m_wr,
    input  logic [NUM_M*AW-1:0] m_address,
    input  logic [NUM_M*DW-1:0] m_dout,
    input  logic [NUM_S*DW-1:0] s_dout,
    output logic [NUM_M-1:0]    m_grant,
    output logic [DW-1:0]       m_din,
    output logic [NUM_S-1:0]    s_sel,
    output logic [AW-1:0]       s_address,
    output logic                s_wr,
    output logic [DW-1:0]       s_din,
    output logic                decode_err
);

    logic [2:0]       owner;
    logic [MAX_M-1:0] wr_x;
    logic             s_wr_raw;
    logic [NUM_S-1:0] hit;
    logic [NUM_S-1:0] sel_q;

    bus_arbiter_rr #(
        .NUM_M    (NUM_M),
        .ARB_MODE (ARB_MODE),
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .m_req   (m_req),
        .m_grant (m_grant),
        .owner   (owner)
    );

    always_comb begin
        wr_x      = MAX_M'(m_wr);
        s_address = m_address[int'(owner)*AW +: AW];
        s_din     = m_dout[int'(owner)*DW +: DW];
        // Write strobe is deliberately not gated by m_req, like the legacy bus.
        s_wr_raw  = wr_x[owner];
        for (int i = 0; i < NUM_S; i++) begin
            hit[i] = (s_address & S_MASK[i*AW +: AW]) == S_BASE[i*AW +: AW];
        end
        s_sel = '0;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if (hit[i]) begin
                s_sel    = '0;
                s_sel[i] = 1'b1;
            end
        end
        decode_err = ~|hit;
        s_wr       = s_wr_raw && !decode_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sel_q <= '0;
        else          sel_q <= s_sel;
    end

    // Read data returns one cycle after the access, steered by the registered select.
    always_comb begin
        m_din = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (sel_q[i]) m_din = s_dout[i*DW +: DW];
        end
    end

endmodule

// File: tb/tb_bus_arb_nm.sv
// Scoreboarded bench for bus_arb_nm: a 2-master fixed-priority bus and a
// 4-master round-robin bus with hold limit 3, driven side by side.
module tb_bus_arb_nm;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int W  = 8 + NS + 1 + 1 + AW + DW + DW;

    localparam int NM[2]   = '{2, 4};
    localparam int MODE[2] = '{0, 1};
    localparam int HOLD[2] = '{0, 3};
    localparam int LO[4]   = '{'h00, 'h10, 'h20, 'h40};
    localparam int HI[4]   = '{'h0F, 'h1F, 'h3F, 'h7F};
    localparam logic [7:0] T2_ADDR[5] = '{8'h05, 8'h1F, 8'h3A, 8'h7F, 8'h80};
    localparam logic [7:0] T3_REQ[5]  = '{8'h3, 8'h2, 8'h3, 8'h0, 8'h1};
    localparam logic [7:0] T4_REQ[5]  = '{8'h2, 8'hB, 8'h9, 8'h1, 8'h0};

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // stimulus state, packed onto the DUT ports below
    logic [7:0]    mreq[2];
    logic [7:0]    mwr[2];
    logic [AW-1:0] addrs[2][8];
    logic [DW-1:0] wdata[2][8];
    logic [DW-1:0] sdout[NS];

    logic [1:0]      a_req, a_wr, a_grant;
    logic [2*AW-1:0] a_address;
    logic [2*DW-1:0] a_dout;
    logic [DW-1:0]   a_m_din, a_s_din;
    logic [NS-1:0]   a_s_sel;
    logic [AW-1:0]   a_s_address;
    logic            a_s_wr, a_derr;

    logic [3:0]      b_req, b_wr, b_grant;
    logic [4*AW-1:0] b_address;
    logic [4*DW-1:0] b_dout;
    logic [DW-1:0]   b_m_din, b_s_din;
    logic [NS-1:0]   b_s_sel;
    logic [AW-1:0]   b_s_address;
    logic            b_s_wr, b_derr;

    logic [NS*DW-1:0] s_dout;

    always_comb begin
        a_address = '0;
        a_dout    = '0;
        b_address = '0;
        b_dout    = '0;
        s_dout    = '0;
        a_req     = mreq[0][1:0];
        a_wr      = mwr[0][1:0];
        b_req     = mreq[1][3:0];
        b_wr      = mwr[1][3:0];
        for (int i = 0; i < 2; i++) begin
            a_address[i*AW +: AW] = addrs[0][i];
            a_dout[i*DW +: DW]    = wdata[0][i];
        end
        for (int i = 0; i < 4; i++) begin
            b_address[i*AW +: AW] = addrs[1][i];
            b_dout[i*DW +: DW]    = wdata[1][i];
        end
        for (int s = 0; s < NS; s++) s_dout[s*DW +: DW] = sdout[s];
    end

    bus_arb_nm #(
        .NUM_M(2), .NUM_S(NS), .AW(AW), .DW(DW), .ARB_MODE(0), .MAX_HOLD(0),
        .S_BASE(32'h40201000), .S_MASK(32'hC0E0F0F0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .m_req(a_req), .m_wr(a_wr),
        .m_address(a_address), .m_dout(a_dout), .s_dout(s_dout),
        .m_grant(a_grant), .m_din(a_m_din), .s_sel(a_s_sel),
        .s_address(a_s_address), .s_wr(a_s_wr), .s_din(a_s_din), .decode_err(a_derr)
    );

    bus_arb_nm #(
        .NUM_M(4), .NUM_S(NS), .AW(AW), .DW(DW), .ARB_MODE(1), .MAX_HOLD(3),
        .S_BASE(32'h40201000), .S_MASK(32'hC0E0F0F0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .m_req(b_req), .m_wr(b_wr),
        .m_address(b_address), .m_dout(b_dout), .s_dout(s_dout),
        .m_grant(b_grant), .m_din(b_m_din), .s_sel(b_s_sel),
        .s_address(b_s_address), .s_wr(b_s_wr), .s_din(b_s_din), .decode_err(b_derr)
    );

    // reference model: owner, contested-cycle count, slave index latched for read return
    int own[2];
    int hold[2];
    int selq[2];

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int n_checks = 0;
    int n_fail   = 0;
    int rst_armed = 0;
    int rst_seen  = 0;

    function automatic int decode(input logic [7:0] a);
        for (int s = 0; s < NS; s++) begin
            if (int'(a) >= LO[s] && int'(a) <= HI[s]) return s;
        end
        return -1;
    endfunction

    function automatic int pick(input int k, input int o);
        int n = NM[k];
        for (int d = 1; d < n; d++) begin
            int i;
            i = (MODE[k] == 1) ? (o + d) % n : ((d <= o) ? d - 1 : d);
            if (mreq[k][i]) return i;
        end
        return o;
    endfunction

    task automatic model_reset(input int k);
        own[k]  = 0;
        hold[k] = 0;
        selq[k] = -1;
    endtask

    task automatic model_step(input int k);
        int  o, waiting;
        bit  ownr, sw;
        o       = own[k];
        selq[k] = decode(addrs[k][o]);
        ownr    = mreq[k][o];
        waiting = 0;
        for (int i = 0; i < NM[k]; i++) if (i != o && mreq[k][i]) waiting++;
        sw = 1'b0;
        if (waiting > 0 && !ownr) sw = 1'b1;
        if (waiting > 0 && ownr && HOLD[k] > 0 && hold[k] + 1 >= HOLD[k]) sw = 1'b1;
        if (sw) begin
            own[k]  = pick(k, o);
            hold[k] = 0;
        end else if (waiting == 0) begin
            hold[k] = 0;
        end else if (HOLD[k] > 0 && hold[k] < HOLD[k] - 1) begin
            hold[k] = hold[k] + 1;
        end
    endtask

    function automatic logic [W-1:0] exp_out(input int k);
        int         o, s;
        logic [7:0] g;
        logic [3:0] sel;
        logic       derr, swr;
        logic [31:0] md;
        o    = own[k];
        s    = decode(addrs[k][o]);
        g    = 8'(1 << o);
        sel  = (s < 0) ? 4'd0 : 4'(1 << s);
        derr = (s < 0);
        swr  = mwr[k][o] && (s >= 0);
        md   = (selq[k] < 0) ? 32'd0 : sdout[selq[k]];
        return {g, sel, derr, swr, addrs[k][o], wdata[k][o], md};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) model_reset(k);
            else          model_step(k);
        end
        #1;
    endtask

    task automatic publish();
        exp_q0.push_back(exp_out(0));
        exp_q1.push_back(exp_out(1));
    endtask

    // scoreboard / monitor
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cmp_unit(input string tag, input logic [W-1:0] e, input logic [7:0] g,
                            input logic [3:0] sel, input logic derr, input logic swr,
                            input logic [7:0] sa, input logic [31:0] sd, input logic [31:0] md);
        check({tag, ".m_grant"},    32'(g),    32'(e[85:78]));
        check({tag, ".s_sel"},      32'(sel),  32'(e[77:74]));
        check({tag, ".decode_err"}, 32'(derr), 32'(e[73]));
        check({tag, ".s_wr"},       32'(swr),  32'(e[72]));
        check({tag, ".s_address"},  32'(sa),   32'(e[71:64]));
        check({tag, ".s_din"},      sd,        e[63:32]);
        check({tag, ".m_din"},      md,        e[31:0]);
    endtask

    logic [W-1:0] e0, e1;
    initial begin
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n && rst_seen != rst_armed) begin
                rst_seen = rst_armed;
                #1;
                check("rst.a_grant", 32'(a_grant), 32'd1);
                check("rst.a_m_din", a_m_din, 32'd0);
                check("rst.b_grant", 32'(b_grant), 32'd1);
                check("rst.b_m_din", b_m_din, 32'd0);
            end else if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
                e0 = exp_q0.pop_front();
                e1 = exp_q1.pop_front();
                cmp_unit("a", e0, 8'(a_grant), a_s_sel, a_derr, a_s_wr, a_s_address, a_s_din, a_m_din);
                cmp_unit("b", e1, 8'(b_grant), b_s_sel, b_derr, b_s_wr, b_s_address, b_s_din, b_m_din);
            end
        end
    end

    // stimulus
    initial begin
        for (int k = 0; k < 2; k++) begin
            mreq[k] = '0;
            mwr[k]  = '0;
            for (int i = 0; i < 8; i++) begin
                addrs[k][i] = '0;
                wdata[k][i] = 32'h100 * (k + 1) + i;
            end
            model_reset(k);
        end
        for (int s = 0; s < NS; s++) sdout[s] = s + 1;

        // reset, then idle bus parked on master 0
        repeat (2) tick();
        reset_n = 1'b1;
        publish();
        tick(); publish();

        // window decode and one-cycle read return
        for (int t = 0; t < 5; t++) begin
            tick();
            addrs[0][0] = T2_ADDR[t];
            addrs[1][0] = T2_ADDR[t];
            mwr[0] = 8'h1;
            mwr[1] = 8'h1;
            publish();
        end
        tick(); publish();

        // sticky grant and parking on the fixed-priority bus
        for (int t = 0; t < 5; t++) begin
            tick(); mreq[0] = T3_REQ[t]; publish();
            tick(); publish();
        end

        // round-robin hand-over on the 4-master bus
        for (int t = 0; t < 5; t++) begin
            tick(); mreq[1] = T4_REQ[t]; publish();
        end
        tick(); publish();

        // hold limit with two masters requesting continuously
        tick(); mreq[1] = 8'h3; publish();
        repeat (8) begin tick(); publish(); end

        // master 1 owns and writes, then reset arrives between edges
        tick();
        mreq[0] = 8'h2; mwr[0] = 8'h2; addrs[0][1] = 8'h12;
        mreq[1] = 8'h2; mwr[1] = 8'h2; addrs[1][1] = 8'h12;
        publish();
        tick(); publish();
        @(negedge clk);
        #2;
        rst_armed = rst_armed + 1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        mreq[0] = '0;
        mreq[1] = '0;
        publish();

        // randomized traffic
        repeat (1500) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 3) == 0) mreq[k] = 8'($urandom_range(0, 255));
                mwr[k] = 8'($urandom_range(0, 255));
                for (int i = 0; i < 8; i++) begin
                    addrs[k][i] = 8'($urandom_range(0, 255));
                    wdata[k][i] = $urandom;
                end
            end
            for (int s = 0; s < NS; s++) sdout[s] = $urandom;
            publish();
        end

        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
